lif_wta_layer: RTL and testbench

- Spiking neuron layer: 2 leaky integrate-and-fire (LIF) neurons, fully connected to 4 input spike lines through programmable unsigned weights.
- Sits directly downstream of the 4-line spike delay stage and consumes its delayed spike bus.
- Winner-take-all (WTA) lateral inhibition: at most one neuron fires per cycle.
- The 2-bit output spike vector is the event trigger fed back to the delay stage's 2-bit event input.

---
 rtl/lif_wta_layer.sv | 134 +++++++++++++
 tb/tb_lif_wta_layer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/lif_wta_layer.sv
// Two-neuron leaky integrate-and-fire layer with programmable 4-input weights
// and winner-take-all lateral inhibition followed by a shared refractory period.
module lif_wta_layer #(
  parameter int p_w_width     = 4,
  parameter int p_pot_width   = 8,
  parameter int p_threshold   = 20,
  parameter int p_leak_period = 8,
  parameter int p_refractory  = 4,
  parameter int p_w_init      = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [3:0]               i_spike,
  input  logic                     i_wr_en,
  input  logic [2:0]               i_wr_addr,
  input  logic [p_w_width-1:0]     i_wr_data,
  output logic [1:0]               o_spike,
  output logic                     o_busy,
  output logic [2*p_pot_width-1:0] o_pot
);

  localparam int c_sum_w = p_w_width + 2;
  localparam int c_ext_w = ((p_pot_width > c_sum_w) ? p_pot_width : c_sum_w) + 1;
  localparam int c_lk_w  = (p_leak_period > 1) ? $clog2(p_leak_period) : 1;
  localparam int c_rf_w  = $clog2(p_refractory + 1);

  localparam logic [p_pot_width-1:0] c_pot_max = '1;
  localparam logic [p_pot_width-1:0] c_thr     = p_pot_width'(p_threshold);
  localparam logic [c_lk_w-1:0]      c_lk_last = c_lk_w'(p_leak_period - 1);
  localparam logic [c_rf_w-1:0]      c_rf_load = c_rf_w'(p_refractory);
  localparam logic [p_w_width-1:0]   c_w_init  = p_w_width'(p_w_init);

  logic [p_w_width-1:0]   weight_q [8];
  logic [p_w_width-1:0]   weight_d [8];
  logic [p_pot_width-1:0] pot_q    [2];
  logic [p_pot_width-1:0] pot_d    [2];
  logic [c_lk_w-1:0]      lk_cnt_q, lk_cnt_d;
  logic [c_rf_w-1:0]      rf_cnt_q, rf_cnt_d;
  logic [1:0]             spike_q, spike_d;
  logic                   busy_q, busy_d;

  logic [c_sum_w-1:0]     sum [2];
  logic [c_ext_w-1:0]     ext [2];
  logic [p_pot_width-1:0] nxt [2];
  logic [1:0]             cand;
  logic                   win1;
  logic                   leak;

  always_comb begin
    weight_d = weight_q;
    if (i_wr_en) begin
      weight_d[i_wr_addr] = i_wr_data;
    end else begin
      weight_d = weight_q;
    end
  end

  always_comb begin
    leak = (lk_cnt_q == c_lk_last);
    if (leak) begin
      lk_cnt_d = '0;
    end else begin
      lk_cnt_d = lk_cnt_q + c_lk_w'(1);
    end
  end

  // Integrate at full width, then saturate at both ends before the fire decision.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      sum[n] = '0;
      for (int l = 0; l < 4; l++) begin
        sum[n] = sum[n] + (i_spike[l] ? c_sum_w'(weight_q[n*4+l]) : '0);
      end
      ext[n] = c_ext_w'(pot_q[n]) + c_ext_w'(sum[n]);
      if (leak && (ext[n] != '0)) begin
        ext[n] = ext[n] - c_ext_w'(1);
      end else begin
        ext[n] = ext[n];
      end
      if (ext[n] > c_ext_w'(c_pot_max)) begin
        nxt[n] = c_pot_max;
      end else begin
        nxt[n] = ext[n][p_pot_width-1:0];
      end
      cand[n] = (nxt[n] >= c_thr);
    end
    win1 = cand[1] & (~cand[0] | (nxt[1] > nxt[0]));

    if (rf_cnt_q != '0) begin
      pot_d[0] = '0;
      pot_d[1] = '0;
      spike_d  = 2'b00;
      rf_cnt_d = rf_cnt_q - c_rf_w'(1);
    end else if (cand != 2'b00) begin
      pot_d[0] = '0;
      pot_d[1] = '0;
      spike_d  = win1 ? 2'b10 : 2'b01;
      rf_cnt_d = c_rf_load;
    end else begin
      pot_d[0] = nxt[0];
      pot_d[1] = nxt[1];
      spike_d  = 2'b00;
      rf_cnt_d = '0;
    end
    busy_d = (rf_cnt_d != '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 8; i++) begin
        weight_q[i] <= c_w_init;
      end
      pot_q[0] <= '0;
      pot_q[1] <= '0;
      lk_cnt_q <= '0;
      rf_cnt_q <= '0;
      spike_q  <= 2'b00;
      busy_q   <= 1'b0;
    end else begin
      weight_q <= weight_d;
      pot_q[0] <= pot_d[0];
      pot_q[1] <= pot_d[1];
      lk_cnt_q <= lk_cnt_d;
      rf_cnt_q <= rf_cnt_d;
      spike_q  <= spike_d;
      busy_q   <= busy_d;
    end
  end

  assign o_spike = spike_q;
  assign o_busy  = busy_q;
  assign o_pot   = {pot_q[1], pot_q[0]};

endmodule

// File: tb/tb_lif_wta_layer.sv
// Directed bench for lif_wta_layer: default instance plus a threshold-255
// instance used for the saturation scenario.
module tb_lif_wta_layer;

  logic        clk;
  logic        rst_n;
  logic [3:0]  spike;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [3:0]  wr_data;
  logic [1:0]  o_spike;
  logic        o_busy;
  logic [15:0] o_pot;

  logic [3:0]  s_spike;
  logic        s_wr_en;
  logic [2:0]  s_wr_addr;
  logic [3:0]  s_wr_data;
  logic [1:0]  s_o_spike;
  logic        s_o_busy;
  logic [15:0] s_o_pot;

  int n_checks;
  int n_fail;

  lif_wta_layer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_spike(spike), .i_wr_en(wr_en),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_spike(o_spike), .o_busy(o_busy), .o_pot(o_pot)
  );

  lif_wta_layer #(.p_threshold(255)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_spike(s_spike), .i_wr_en(s_wr_en),
    .i_wr_addr(s_wr_addr), .i_wr_data(s_wr_data),
    .o_spike(s_o_spike), .o_busy(s_o_busy), .o_pot(s_o_pot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    spike = 4'b0000; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 4'd0;
    s_spike = 4'b0000; s_wr_en = 1'b0; s_wr_addr = 3'd0; s_wr_data = 4'd0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    n_checks++;
    if (o_spike !== 2'b00) begin n_fail++; $display("FAIL reset_spike got %b want 00", o_spike); end
    n_checks++;
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", o_busy); end
    n_checks++;
    if (o_pot !== 16'h0000) begin n_fail++; $display("FAIL reset_pot got %h want 0000", o_pot); end
  endtask

  task automatic test_basic_fire();
    do_reset();
    spike = 4'b1111;
    step();
    n_checks++;
    if (o_pot !== {8'd16, 8'd16}) begin n_fail++; $display("FAIL basic_pot1 got %h want 1010", o_pot); end
    n_checks++;
    if (o_spike !== 2'b00) begin n_fail++; $display("FAIL basic_nospike1 got %b want 00", o_spike); end
    step();
    spike = 4'b0000;
    n_checks++;
    if (o_spike !== 2'b01) begin n_fail++; $display("FAIL basic_tie_spike got %b want 01", o_spike); end
    n_checks++;
    if (o_pot !== 16'h0000) begin n_fail++; $display("FAIL basic_inhibit got %h want 0000", o_pot); end
    n_checks++;
    if (o_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy0 got %b want 1", o_busy); end
    for (int i = 1; i < 4; i++) begin
      step();
      n_checks++;
      if (o_busy !== 1'b1 || o_spike !== 2'b00) begin
        n_fail++; $display("FAIL basic_busy%0d busy %b spike %b want 1 00", i, o_busy, o_spike);
      end
    end
    step();
    n_checks++;
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end got %b want 0", o_busy); end
  endtask

  task automatic test_refractory();
    do_reset();
    spike = 4'b1111;
    step();
    step();
    n_checks++;
    if (o_spike !== 2'b01) begin n_fail++; $display("FAIL refr_fire got %b want 01", o_spike); end
    for (int i = 1; i < 4; i++) begin
      step();
      n_checks++;
      if (o_pot !== 16'h0000 || o_spike !== 2'b00 || o_busy !== 1'b1) begin
        n_fail++; $display("FAIL refr_mask%0d pot %h spike %b busy %b want 0000 00 1", i, o_pot, o_spike, o_busy);
      end
    end
    step();
    n_checks++;
    if (o_pot !== 16'h0000 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL refr_last pot %h busy %b want 0000 0", o_pot, o_busy);
    end
    step();
    spike = 4'b0000;
    n_checks++;
    if (o_pot !== {8'd16, 8'd16} || o_spike !== 2'b00) begin
      n_fail++; $display("FAIL refr_resume pot %h spike %b want 1010 00", o_pot, o_spike);
    end
  endtask

  task automatic test_write_timing();
    do_reset();
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'd0; spike = 4'b0001;
    step();
    wr_en = 1'b0;
    n_checks++;
    if (o_pot !== {8'd4, 8'd4}) begin n_fail++; $display("FAIL wr_old_weight got %h want 0404", o_pot); end
    step();
    spike = 4'b0000;
    n_checks++;
    if (o_pot !== {8'd8, 8'd4}) begin n_fail++; $display("FAIL wr_new_weight got %h want 0804", o_pot); end
  endtask

  task automatic test_wta();
    do_reset();
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 4'd15;
    step();
    wr_en = 1'b0; spike = 4'b1000;
    step();
    n_checks++;
    if (o_pot !== {8'd15, 8'd4}) begin n_fail++; $display("FAIL wta_pot got %h want 0f04", o_pot); end
    step();
    spike = 4'b0000;
    n_checks++;
    if (o_spike !== 2'b10) begin n_fail++; $display("FAIL wta_spike got %b want 10", o_spike); end
    n_checks++;
    if (o_pot !== 16'h0000) begin n_fail++; $display("FAIL wta_inhibit got %h want 0000", o_pot); end
  endtask

  task automatic test_leak();
    logic [7:0] exp_p;
    do_reset();
    spike = 4'b0001;
    step();
    spike = 4'b0000;
    n_checks++;
    if (o_pot !== {8'd4, 8'd4}) begin n_fail++; $display("FAIL leak_start got %h want 0404", o_pot); end
    for (int e = 1; e <= 40; e++) begin
      step();
      exp_p = ((e + 1) / 8 >= 4) ? 8'd0 : 8'(4 - (e + 1) / 8);
      n_checks++;
      if (o_pot !== {exp_p, exp_p}) begin
        n_fail++; $display("FAIL leak_edge%0d got %h want %h", e, o_pot, {exp_p, exp_p});
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int a = 0; a < 8; a++) begin
      s_wr_en = 1'b1; s_wr_addr = 3'(a); s_wr_data = 4'd15;
      step();
    end
    s_wr_en = 1'b0;
    n_checks++;
    if (s_o_pot !== 16'h0000) begin n_fail++; $display("FAIL sat_floor got %h want 0000", s_o_pot); end
    s_spike = 4'b1111;
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (s_o_pot !== {8'd240, 8'd240} || s_o_spike !== 2'b00) begin
      n_fail++; $display("FAIL sat_240 pot %h spike %b want f0f0 00", s_o_pot, s_o_spike);
    end
    step();
    s_spike = 4'b0000;
    n_checks++;
    if (s_o_spike !== 2'b01 || s_o_pot !== 16'h0000) begin
      n_fail++; $display("FAIL sat_fire spike %b pot %h want 01 0000", s_o_spike, s_o_pot);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'd1;
    step();
    wr_addr = 3'd4;
    step();
    wr_en = 1'b0; spike = 4'b1111;
    step();
    n_checks++;
    if (o_pot !== {8'd13, 8'd13}) begin n_fail++; $display("FAIL arst_pre got %h want 0d0d", o_pot); end
    step();
    spike = 4'b0000;
    n_checks++;
    if (o_spike !== 2'b01) begin n_fail++; $display("FAIL arst_fire got %b want 01", o_spike); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_spike !== 2'b00 || o_busy !== 1'b0 || o_pot !== 16'h0000) begin
      n_fail++; $display("FAIL arst_clear spike %b busy %b pot %h want 00 0 0000", o_spike, o_busy, o_pot);
    end
    step();
    rst_n = 1'b1;
    spike = 4'b1111;
    step();
    spike = 4'b0000;
    n_checks++;
    if (o_pot !== {8'd16, 8'd16}) begin n_fail++; $display("FAIL arst_weights got %h want 1010", o_pot); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    do_reset();
    test_reset();
    test_basic_fire();
    test_refractory();
    test_write_timing();
    test_wta();
    test_leak();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
